// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Time-shares one registered W-bit adder between NREQ requesters.
// A round-robin arbiter picks a requester in IDLE and captures its operands.
// A four-state sequencer then drives the adder enable and waits out the
// adder's register stage. The sum is returned tagged with the requester id
// over a valid/ready handshake.
// Only one operation is ever outstanding.

module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_en,
  input  logic [W-1:0]      add_sum,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_sum,
  input  logic              resp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  logic [IDW-1:0]   ptr_q,        ptr_d;
  logic [W-1:0]     add_a_q,      add_a_d;
  logic [W-1:0]     add_b_q,      add_b_d;
  logic [IDW-1:0]   resp_id_q,    resp_id_d;
  logic [W-1:0]     resp_sum_q,   resp_sum_d;
  logic             resp_valid_q, resp_valid_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant_onehot;
  logic             grant_fire;
  logic [W-1:0]     win_a;
  logic [W-1:0]     win_b;

  // Round-robin search: the first set request strictly after the pointer,
  // wrapping modulo NREQ. The pointer itself is checked last, so the most
  // recent winner has the lowest priority.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
    logic [IDW-1:0] pick;
    logic           hit;
    int             idx;
    pick = '0;
    hit  = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(p) + off) % NREQ;
      if (!hit && r[idx[IDW-1:0]]) begin
        hit  = 1'b1;
        pick = idx[IDW-1:0];
      end
    end
    return pick;
  endfunction

  // Arbiter: choose a winner from the live request vector and select its operands.
  always_comb begin
    grant_found  = |req;
    grant_idx    = rr_pick(req, ptr_q);
    grant_onehot = '0;
    grant_onehot[grant_idx] = 1'b1;
    win_a        = a_in[int'(grant_idx)*W +: W];
    win_b        = b_in[int'(grant_idx)*W +: W];
  end

  // Sequencer: next state plus the grant and adder-enable strobes.
  // While enable is low, every adder-facing strobe is suppressed and the state
  // holds. The only exception is the response handshake, which never touches
  // the adder.
  always_comb begin
    state_d    = state_q;
    gnt        = '0;
    add_en     = 1'b0;
    grant_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && grant_found) begin
          gnt        = grant_onehot;
          grant_fire = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (enable) begin
          add_en  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (enable) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: operand capture at grant, sum capture after the
  // adder's register stage, and valid release on handshake.
  always_comb begin
    ptr_d        = ptr_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_valid_d = resp_valid_q;

    if (grant_fire) begin
      ptr_d     = grant_idx;
      add_a_d   = win_a;
      add_b_d   = win_b;
      resp_id_d = grant_idx;
    end

    // The adder registered its sum on the ISSUE edge, so it is valid here.
    if (state_q == WAIT && enable) begin
      resp_sum_d   = add_sum;
      resp_valid_d = 1'b1;
    end

    if (state_q == RESP && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // State and datapath registers. A synchronous reset discards any in-flight
  // operation without a response. It also points the arbiter at NREQ-1, so
  // requester 0 wins first.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Output wiring from the registered state.
  always_comb begin
    add_a      = add_a_q;
    add_b      = add_b_q;
    resp_id    = resp_id_q;
    resp_sum   = resp_sum_q;
    resp_valid = resp_valid_q;
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter.
// It contains a registered adder model and a transaction-level reference.
// The reference covers round-robin order, modular sum, and the fixed
// grant / issue / response timeline.
`timescale 1ns/1ps

module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clock;
  logic              reset_n;
  logic              enable;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_en;
  logic [W-1:0]      add_sum;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_ready;
  logic              busy;

  int passed = 0;
  int total  = 0;
  int rr_ptr = NREQ - 1;

  adder_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_en     (add_en),
    .add_sum    (add_sum),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared adder: registers the sum on an edge where add_en is high.
  always_ff @(posedge clock) begin
    if (add_en) add_sum <= add_a + add_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference arbiter: first requester after the last winner, modulo NREQ.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int off = 1; off <= NREQ; off++) begin
      if (r[(rr_ptr + off) % NREQ]) return (rr_ptr + off) % NREQ;
    end
    return -1;
  endfunction

  // One full operation starting in an IDLE cycle.
  // The winner's operands are a/b and the other slices are random.
  // The response is stalled for 'hold' cycles, then accepted.
  task automatic do_op(input logic [NREQ-1:0] r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold, input int exp_id);
    int k;
    logic [W-1:0] es;
    k  = model_pick(r);
    es = W'((int'(a) + int'(b)) % 256);
    if (exp_id >= 0) check("model_id", 32'(k), 32'(exp_id));
    req  = r;
    a_in = $urandom;
    b_in = $urandom;
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
    #1;
    check("gnt", 32'(gnt), 32'(1) << k);
    check("busy_idle", 32'(busy), 0);
    cyc();
    // Operands must have been captured at the grant, not tracked afterwards.
    a_in = $urandom;
    b_in = $urandom;
    #1;
    check("add_en_issue", 32'(add_en), 1);
    check("gnt_issue", 32'(gnt), 0);
    check("add_a", 32'(add_a), 32'(a));
    check("add_b", 32'(add_b), 32'(b));
    check("busy_issue", 32'(busy), 1);
    cyc();
    check("add_en_wait", 32'(add_en), 0);
    check("valid_wait", 32'(resp_valid), 0);
    cyc();
    check("valid_resp", 32'(resp_valid), 1);
    check("resp_sum", 32'(resp_sum), 32'(es));
    check("resp_id", 32'(resp_id), 32'(k));
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cyc();
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_sum", 32'(resp_sum), 32'(es));
      check("hold_id", 32'(resp_id), 32'(k));
      check("hold_gnt", 32'(gnt), 0);
    end
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    check("valid_after_accept", 32'(resp_valid), 0);
    check("busy_after_accept", 32'(busy), 0);
    rr_ptr = k;
  endtask

  initial begin
    int k;
    reset_n    = 1'b0;
    enable     = 1'b1;
    req        = '0;
    a_in       = '0;
    b_in       = '0;
    resp_ready = 1'b0;
    add_sum    = '0;
    cyc();
    cyc();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_add_en", 32'(add_en), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_add_a", 32'(add_a), 0);
    check("rst_resp_sum", 32'(resp_sum), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    reset_n = 1'b1;
    cyc();

    // Single request.
    do_op(4'b0001, 8'h12, 8'h34, 0, 0);

    // Reset again, then all four request: order 0,1,2,3,0.
    reset_n = 1'b0; cyc(); reset_n = 1'b1; rr_ptr = NREQ - 1;
    do_op(4'b1111, 8'h01, 8'h02, 0, 0);
    do_op(4'b1111, 8'h03, 8'h04, 0, 1);
    do_op(4'b1111, 8'h05, 8'h06, 0, 2);
    do_op(4'b1111, 8'h07, 8'h08, 0, 3);
    do_op(4'b1111, 8'h09, 8'h0A, 0, 0);

    // Fairness after a grant to 2.
    do_op(4'b0100, 8'h10, 8'h20, 0, 2);
    do_op(4'b1010, 8'h11, 8'h22, 0, 3);
    do_op(4'b1010, 8'h13, 8'h24, 0, 1);

    // Overflow wraps.
    do_op(4'b0001, 8'hFF, 8'h01, 0, -1);
    do_op(4'b0001, 8'h80, 8'h80, 0, -1);
    do_op(4'b0001, 8'hAA, 8'h55, 0, -1);

    // Backpressure for 5 cycles with everyone requesting.
    do_op(4'b1111, 8'h3C, 8'h4D, 5, -1);
    do_op(4'b1111, 8'h5E, 8'h6F, 0, -1);

    // enable low in IDLE suppresses grants.
    enable = 1'b0;
    req    = 4'b1111;
    #1;
    check("dis_gnt", 32'(gnt), 0);
    cyc();
    check("dis_busy", 32'(busy), 0);
    enable = 1'b1;

    // Reset while in WAIT drops the operation.
    req  = 4'b0010;
    a_in = 32'h00007700;
    b_in = 32'h00001100;
    #1;
    cyc();
    cyc();
    check("pre_rst_wait_busy", 32'(busy), 1);
    reset_n = 1'b0;
    req     = '0;
    cyc();
    reset_n = 1'b1;
    rr_ptr  = NREQ - 1;
    check("wrst_valid", 32'(resp_valid), 0);
    check("wrst_busy", 32'(busy), 0);
    check("wrst_add_a", 32'(add_a), 0);
    check("wrst_add_b", 32'(add_b), 0);
    check("wrst_resp_sum", 32'(resp_sum), 0);
    check("wrst_resp_id", 32'(resp_id), 0);
    cyc();
    check("wrst_no_resp", 32'(resp_valid), 0);

    // enable low while in ISSUE freezes the sequencer.
    req  = 4'b0100;
    k    = model_pick(req);
    a_in = '0;
    b_in = '0;
    a_in[k*W +: W] = 8'hC3;
    b_in[k*W +: W] = 8'h4A;
    #1;
    check("frz_gnt", 32'(gnt), 32'(1) << k);
    cyc();
    enable = 1'b0;
    #1;
    check("frz_add_en", 32'(add_en), 0);
    cyc();
    cyc();
    check("frz_add_en2", 32'(add_en), 0);
    check("frz_busy", 32'(busy), 1);
    check("frz_valid", 32'(resp_valid), 0);
    enable = 1'b1;
    #1;
    check("frz_resume_add_en", 32'(add_en), 1);
    cyc();
    cyc();
    check("frz_valid_resp", 32'(resp_valid), 1);
    check("frz_sum", 32'(resp_sum), 32'h0D);
    check("frz_id", 32'(resp_id), 32'(k));
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    check("frz_accept", 32'(resp_valid), 0);
    rr_ptr = k;

    // Randomized operations.
    for (int n = 0; n < 24; n++) begin
      do_op(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom),
            int'($urandom_range(0, 3)), -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
